// File: rtl/even_odd_feeder.sv
// Front-end feeder for the EVEN_ODD sorting network. It packs a record stream into
// padded 2^P_LOG-lane blocks and limits the number of blocks in flight using returned pulses.
module even_odd_feeder #(
    parameter int              P_LOG    = 4,
    parameter int              KEYW     = 32,
    parameter int              PAYW     = 32,
    parameter int              DATW     = PAYW + KEYW,
    parameter int              MAX_INFL = 8,
    parameter logic [KEYW-1:0] PAD_KEY  = {KEYW{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATW-1:0]           s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [(DATW<<P_LOG)-1:0]  net_din,
    output logic                      net_dinen,
    input  logic                      net_doten,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               blk_cnt,
    output logic                      err
);

    localparam int                        LANES    = 1 << P_LOG;
    localparam int                        IW       = $clog2(MAX_INFL + 1);
    localparam logic [IW-1:0]             MAX_C    = IW'(MAX_INFL);
    localparam logic [DATW-1:0]           PAD_REC  = {{PAYW{1'b0}}, PAD_KEY};
    localparam logic [DATW*LANES-1:0]     PAD_BLK  = {LANES{PAD_REC}};
    localparam logic [P_LOG-1:0]          LAST_IDX = {P_LOG{1'b1}};

    // state | meaning
    // FILL  | accepting records into the fill buffer
    // DRAIN | job's last block issued, waiting for all blocks to return
    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]            state_q;
    logic [P_LOG-1:0]      idx_q;
    logic [IW-1:0]         infl_q;
    logic [IW-1:0]         infl_nxt;
    logic [DATW*LANES-1:0] buf_q;
    logic [DATW*LANES-1:0] blk_nxt;
    logic                  first_q;
    logic                  accept;
    logic                  complete;
    logic                  dec;

    assign s_ready  = (state_q == ST_FILL) && (infl_q < MAX_C);
    assign accept   = s_valid && s_ready;
    assign complete = accept && (s_last || (idx_q == LAST_IDX));
    assign dec      = net_doten && (infl_q != '0);
    assign busy     = (state_q == ST_DRAIN) || (idx_q != '0) || (infl_q != '0);

    always_comb begin
        blk_nxt = buf_q;
        blk_nxt[int'(idx_q)*DATW +: DATW] = s_data;
    end

    // Credit is reserved on the completion cycle, so a same-cycle return nets to zero.
    always_comb begin
        infl_nxt = infl_q;
        if (complete && !dec)
            infl_nxt = infl_q + 1'b1;
        else if (!complete && dec)
            infl_nxt = infl_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_FILL;
            idx_q     <= '0;
            infl_q    <= '0;
            buf_q     <= PAD_BLK;
            first_q   <= 1'b1;
            net_din   <= '0;
            net_dinen <= 1'b0;
            done      <= 1'b0;
            blk_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            net_dinen <= complete;
            done      <= 1'b0;
            infl_q    <= infl_nxt;
            if (complete)
                net_din <= blk_nxt;
            if (net_doten && (infl_q == '0))
                err <= 1'b1;
            if (accept) begin
                first_q <= s_last;
                if (complete) begin
                    buf_q <= PAD_BLK;
                    idx_q <= '0;
                end else begin
                    buf_q <= blk_nxt;
                    idx_q <= idx_q + 1'b1;
                end
                if (first_q)
                    blk_cnt <= complete ? 32'd1 : 32'd0;
                else if (complete)
                    blk_cnt <= blk_cnt + 32'd1;
                if (s_last)
                    state_q <= ST_DRAIN;
            end
            if ((state_q == ST_DRAIN) && (infl_nxt == '0)) begin
                done    <= 1'b1;
                state_q <= ST_FILL;
            end
        end
    end

endmodule

// File: tb/tb_even_odd_feeder.sv
// Randomised bench for even_odd_feeder: a queue-based job model predicts every output
// each cycle while a small network emulator returns blocks after a latency or on release.
module tb_even_odd_feeder;

    localparam int          LANES = 16;
    localparam int          DATW  = 64;
    localparam int          MAXI  = 2;
    localparam int          LAT   = 5;
    localparam logic [63:0] PAD   = {32'h0, 32'hFFFF_FFFF};

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [DATW-1:0]         s_data = '0;
    logic                    s_valid = 1'b0;
    logic                    s_last = 1'b0;
    logic                    s_ready;
    logic [DATW*LANES-1:0]   net_din;
    logic                    net_dinen;
    logic                    net_doten = 1'b0;
    logic                    busy;
    logic                    done;
    logic [31:0]             blk_cnt;
    logic                    err;

    even_odd_feeder #(.MAX_INFL(MAXI)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .net_din(net_din), .net_dinen(net_dinen),
        .net_doten(net_doten), .busy(busy), .done(done), .blk_cnt(blk_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit hold = 1'b0;
    int stall = 0;
    int pending[$];

    logic [63:0]           m_lanes[$];
    int                    m_infl;
    bit                    m_drain, m_err, m_first, m_dinen, m_done;
    int                    m_blk;
    logic [DATW*LANES-1:0] m_din;

    int                    n_dinen, n_done;
    int                    dinen_cyc[$];
    logic [DATW*LANES-1:0] cap_blk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_lanes.delete();
        m_infl = 0; m_drain = 0; m_err = 0; m_first = 1;
        m_dinen = 0; m_done = 0; m_blk = 0; m_din = '0;
        pending.delete();
        stall = 0;
    endtask

    // Drive one cycle, advance the model across the edge, then compare all outputs.
    task automatic cycle(input logic v, input logic [63:0] d, input logic l,
                         input logic force_dt, output bit acc);
        logic dt, rdy, comp, dec, was_drain;
        dt = force_dt;
        acc = 0;
        if (!dt && pending.size() > 0) begin
            if (!hold && pending[0] <= cyc) begin
                dt = 1; void'(pending.pop_front());
            end else if (hold && stall >= 8) begin
                dt = 1; void'(pending.pop_front()); stall = 0;
            end
        end
        s_valid = v; s_data = d; s_last = l; net_doten = dt;
        rdy = !m_drain && (m_infl < MAXI);
        if (rst) check("s_ready", s_ready, rdy);
        if (!rdy) stall++; else stall = 0;
        if (!rst) begin
            model_reset();
        end else begin
            acc = v && rdy;
            comp = 0;
            was_drain = m_drain;
            m_done = 0;
            dec = dt && (m_infl > 0);
            if (dt && m_infl == 0) m_err = 1;
            if (acc) begin
                if (m_first) begin m_blk = 0; m_first = 0; end
                m_lanes.push_back(d);
                if (l || m_lanes.size() == LANES) begin
                    comp = 1;
                    for (int i = 0; i < LANES; i++)
                        m_din[64*i +: 64] = (i < m_lanes.size()) ? m_lanes[i] : PAD;
                    m_lanes.delete();
                    m_blk++;
                    if (l) begin m_drain = 1; m_first = 1; end
                end
            end
            m_infl = m_infl + int'(comp) - int'(dec);
            if (was_drain && m_infl == 0) begin m_done = 1; m_drain = 0; end
            m_dinen = comp;
            if (comp) pending.push_back(cyc + LAT);
        end
        @(posedge clk);
        cyc++;
        #1;
        check("net_dinen", net_dinen, m_dinen);
        check("done", done, m_done);
        check("blk_cnt", blk_cnt, m_blk);
        check("err", err, m_err);
        check("busy", busy, m_drain || (m_lanes.size() != 0) || (m_infl != 0));
        for (int i = 0; i < LANES; i++)
            check($sformatf("net_din_lane%0d", i), net_din[64*i +: 64], m_din[64*i +: 64]);
        if (net_dinen) begin n_dinen++; dinen_cyc.push_back(cyc); cap_blk = net_din; end
        if (done) n_done++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 64'h0, 1'b0, 1'b0, a);
    endtask

    task automatic do_reset();
        bit a;
        rst = 1'b0;
        cycle(1'b0, 64'h0, 1'b0, 1'b0, a);
        rst = 1'b1;
    endtask

    task automatic clr_job();
        n_dinen = 0; n_done = 0; dinen_cyc.delete();
    endtask

    // mode 0: random keys, 1: descending keys n-1..0, 2: keys 7,5,9
    task automatic run_job(input int n, input int gap, input int mode, input bit with_last);
        int k, budget;
        logic [31:0] key;
        logic [31:0] fixed[3];
        bit a, v;
        fixed[0] = 32'd7; fixed[1] = 32'd5; fixed[2] = 32'd9;
        k = 0; budget = 0;
        while (k < n && budget < 4000) begin
            v = ($urandom_range(99) >= gap);
            case (mode)
                1:       key = 32'(n - 1 - k);
                2:       key = fixed[k % 3];
                default: key = $urandom;
            endcase
            cycle(v, {$urandom, key}, with_last && (k == n - 1), 1'b0, a);
            if (a) k++;
            budget++;
        end
        if (k < n) check("job_accept_timeout", 64'(k), 64'(n));
    endtask

    task automatic drain();
        int budget;
        bit a, seen;
        budget = 0; seen = 0;
        while (!seen && budget < 500) begin
            cycle(1'b0, 64'h0, 1'b0, 1'b0, a);
            seen = m_done;
            budget++;
        end
        if (!seen) check("drain_timeout", 64'd0, 64'd1);
        idle(3);
    endtask

    initial begin
        bit a;
        model_reset();
        do_reset();
        do_reset();

        // 1: 32 descending keys, blocks return after a fixed latency
        clr_job();
        run_job(32, 0, 1, 1'b1);
        drain();
        check("t1_blocks", 64'(n_dinen), 64'd2);
        if (dinen_cyc.size() >= 2)
            check("t1_spacing", 64'(dinen_cyc[1] - dinen_cyc[0]), 64'd16);
        check("t1_done_once", 64'(n_done), 64'd1);
        check("t1_blk_cnt", 64'(blk_cnt), 64'd2);
        check("t1_err", 64'(err), 64'd0);

        // 2: short job padded out to a full block
        clr_job();
        run_job(3, 0, 2, 1'b1);
        drain();
        check("t2_blocks", 64'(n_dinen), 64'd1);
        check("t2_lane1", cap_blk[64*1 +: 32], 64'd5);
        check("t2_lane3", cap_blk[64*3 +: 64], PAD);
        check("t2_lane15", cap_blk[64*15 +: 64], PAD);
        check("t2_blk_cnt", 64'(blk_cnt), 64'd1);

        // 3: credit limit with returns withheld until the stream stalls
        hold = 1'b1;
        clr_job();
        run_job(64, 0, 0, 1'b1);
        drain();
        check("t3_blocks", 64'(n_dinen), 64'd4);
        check("t3_done_once", 64'(n_done), 64'd1);
        hold = 1'b0;

        // 4: return coincident with completion, then a return with nothing in flight
        do_reset();
        hold = 1'b1;
        run_job(16, 0, 0, 1'b0);
        run_job(15, 0, 0, 1'b0);
        cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, a);
        check("t4_accepted", 64'(a), 64'd1);
        check("t4_ready", 64'(s_ready), 64'd1);
        cycle(1'b0, 64'h0, 1'b0, 1'b1, a);
        cycle(1'b0, 64'h0, 1'b0, 1'b1, a);
        idle(3);
        check("t4_err_sticky", 64'(err), 64'd1);
        do_reset();
        check("t4_err_cleared", 64'(err), 64'd0);

        // 5: reset in the middle of a job, then a clean job
        run_job(16, 0, 0, 1'b0);
        run_job(9, 0, 0, 1'b0);
        do_reset();
        check("t5_busy", 64'(busy), 64'd0);
        hold = 1'b0;
        clr_job();
        run_job(16, 0, 0, 1'b1);
        drain();
        check("t5_blocks", 64'(n_dinen), 64'd1);
        check("t5_blk_cnt", 64'(blk_cnt), 64'd1);

        // 6: 100 records with random valid gaps
        clr_job();
        run_job(100, 50, 0, 1'b1);
        drain();
        check("t6_blocks", 64'(n_dinen), 64'd7);
        check("t6_done_once", 64'(n_done), 64'd1);
        check("t6_last_lane4", cap_blk[64*4 +: 64], PAD);
        check("t6_blk_cnt", 64'(blk_cnt), 64'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
